// File: rtl/rc5_encrypt_if.sv
// rc5_encrypt_if: start/operand/key-table/result bundle between the RC5 encryptor and its environment.
interface rc5_encrypt_if #(parameter int w = 32, parameter int t_length = 5);
   logic                start;
   logic [w-1:0]        A_plain;
   logic [w-1:0]        B_plain;
   logic [w-1:0]        S_sub_i1;
   logic [w-1:0]        S_sub_i2;
   logic [t_length-1:0] S_address;
   logic                busy;
   logic                done;
   logic [w-1:0]        A_cipher;
   logic [w-1:0]        B_cipher;
   modport master (output start, A_plain, B_plain, S_sub_i1, S_sub_i2,
                   input  S_address, busy, done, A_cipher, B_cipher);
   modport slave  (input  start, A_plain, B_plain, S_sub_i1, S_sub_i2,
                   output S_address, busy, done, A_cipher, B_cipher);
endinterface

// File: rtl/rc5_encrypt.sv
// rc5_encrypt: iterative RC5-w/r encryption, one round per clock, expanded key read from an external table.
module rc5_encrypt #(
   parameter int r = 12,
   parameter int w = 32,
   parameter int t = 26
) (
   input logic clk,
   input logic rst_n,
   rc5_encrypt_if.slave bus
);
   localparam int t_length = $clog2(t);
   localparam int r_length = $clog2(r);
   localparam int rot_length = $clog2(w);
   localparam logic [r_length:0] i_last = (r_length+1)'(r);
   typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;
   state_t state, state_next;
   logic [r_length:0] i;
   logic [w-1:0] a, b, a_round, b_round, a_cipher, b_cipher;
   // Rotating the doubled word makes a shift of zero fall out naturally.
   function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [rot_length-1:0] s);
      logic [2*w-1:0] d;
      d = {x, x} << s;
      return d[2*w-1:w];
   endfunction
   assign a_round = rotl(a ^ b, b[rot_length-1:0]) + bus.S_sub_i1;
   assign b_round = rotl(b ^ a_round, a_round[rot_length-1:0]) + bus.S_sub_i2;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = bus.start ? INIT : IDLE;
         INIT:    state_next = ROUND;
         ROUND:   state_next = (i == i_last) ? DONE : ROUND;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         i <= '0;
         a <= '0;
         b <= '0;
         a_cipher <= '0;
         b_cipher <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (bus.start) begin
               a <= bus.A_plain;
               b <= bus.B_plain;
            end
            INIT: begin
               a <= a + bus.S_sub_i1;
               b <= b + bus.S_sub_i2;
               i <= (r_length+1)'(1);
            end
            ROUND: begin
               a <= a_round;
               b <= b_round;
               i <= i + 1'b1;
               if (i == i_last) begin
                  a_cipher <= a_round;
                  b_cipher <= b_round;
               end
            end
            default: ;
         endcase
      end
   end
   assign bus.busy = (state == INIT) || (state == ROUND);
   assign bus.done = state == DONE;
   assign bus.S_address = (state == ROUND) ? t_length'({i, 1'b0}) : '0;
   assign bus.A_cipher = a_cipher;
   assign bus.B_cipher = b_cipher;
endmodule

// File: tb/tb_rc5_encrypt.sv
// tb_rc5_encrypt: random and directed RC5-32/12 encryptions checked against an arithmetic model and its inverse.
module tb_rc5_encrypt;
   localparam int R = 12;
   logic clk = 1'b0;
   logic rst_n;
   logic [31:0] s_tab [26];
   int checks = 0;
   int errors = 0;
   rc5_encrypt_if #(.w(32), .t_length(5)) bus ();
   rc5_encrypt #(.r(R), .w(32), .t(26)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always_comb begin
      bus.S_sub_i1 = (bus.S_address < 5'd26) ? s_tab[bus.S_address] : 32'h0;
      bus.S_sub_i2 = (bus.S_address < 5'd25) ? s_tab[bus.S_address + 5'd1] : 32'h0;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      int k = n % 32;
      return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
   endfunction
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      int k = n % 32;
      return (k == 0) ? x : ((x >> k) | (x << (32 - k)));
   endfunction
   function automatic logic [63:0] enc(input logic [31:0] pa, input logic [31:0] pb);
      logic [31:0] x = pa + s_tab[0];
      logic [31:0] y = pb + s_tab[1];
      for (int k = 1; k <= R; k++) begin
         x = rl(x ^ y, int'(y % 32)) + s_tab[2*k];
         y = rl(y ^ x, int'(x % 32)) + s_tab[2*k+1];
      end
      return {x, y};
   endfunction
   function automatic logic [63:0] dec(input logic [31:0] ca, input logic [31:0] cb);
      logic [31:0] x = ca;
      logic [31:0] y = cb;
      for (int k = R; k >= 1; k--) begin
         y = rr(y - s_tab[2*k+1], int'(x % 32)) ^ x;
         x = rr(x - s_tab[2*k], int'(y % 32)) ^ y;
      end
      return {x - s_tab[0], y - s_tab[1]};
   endfunction
   task automatic expand_zero_key();
      logic [31:0] l [4];
      logic [31:0] x = 0;
      logic [31:0] y = 0;
      int ii = 0;
      int jj = 0;
      foreach (l[k]) l[k] = 0;
      s_tab[0] = 32'hB7E15163;
      for (int k = 1; k < 26; k++) s_tab[k] = s_tab[k-1] + 32'h9E3779B9;
      for (int k = 0; k < 78; k++) begin
         x = rl(s_tab[ii] + x + y, 3);
         s_tab[ii] = x;
         y = rl(l[jj] + x + y, int'((x + y) % 32));
         l[jj] = y;
         ii = (ii + 1) % 26;
         jj = (jj + 1) % 4;
      end
   endtask
   // One operation from start to the cycle after done; keep holds start high and swaps operands mid-run.
   task automatic run(input logic [31:0] pa, input logic [31:0] pb, input bit keep,
                      input logic [31:0] pa2, input logic [31:0] pb2);
      logic [63:0] prev = {bus.A_cipher, bus.B_cipher};
      logic [63:0] exp = enc(pa, pb);
      int n = 0;
      bus.start = 1'b1;
      bus.A_plain = pa;
      bus.B_plain = pb;
      tick();
      if (!keep) bus.start = 1'b0;
      while (!bus.done && n < 40) begin
         chk("s_address", 64'(bus.S_address), 64'(2*n));
         chk("busy", 64'(bus.busy), 64'd1);
         chk("cipher_hold", {bus.A_cipher, bus.B_cipher}, prev);
         if (keep && n == 4) begin
            bus.A_plain = pa2;
            bus.B_plain = pb2;
         end
         tick();
         n++;
      end
      chk("latency", 64'(n), 64'(R + 1));
      chk("cipher", {bus.A_cipher, bus.B_cipher}, exp);
      chk("done_busy", 64'(bus.busy), 64'd0);
      chk("done_addr", 64'(bus.S_address), 64'd0);
      tick();
      chk("done_pulse", 64'(bus.done), 64'd0);
   endtask
   initial begin
      logic [31:0] a1, b1, a2, b2;
      bit seen;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.A_plain = '0;
      bus.B_plain = '0;
      foreach (s_tab[k]) s_tab[k] = 32'h0;
      repeat (3) tick();
      chk("reset_outputs", {bus.A_cipher, bus.B_cipher}, 64'h0);
      chk("reset_flags", {61'h0, bus.done, bus.busy, 1'b0}, 64'h0);
      chk("reset_addr", 64'(bus.S_address), 64'h0);
      rst_n = 1'b1;
      tick();
      run(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("zero_table", {bus.A_cipher, bus.B_cipher}, 64'h0);
      expand_zero_key();
      run(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("vector", {bus.A_cipher, bus.B_cipher}, 64'hEEDBA521_6D8F4B15);
      chk("idle_addr", 64'(bus.S_address), 64'h0);
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      run(a1, b1, 1'b1, a2, b2);
      chk("hold_idle_busy", 64'(bus.busy), 64'd0);
      chk("hold_idle_cipher", {bus.A_cipher, bus.B_cipher}, enc(a1, b1));
      run(a2, b2, 1'b0, 32'h0, 32'h0);
      bus.start = 1'b1;
      bus.A_plain = $urandom;
      bus.B_plain = $urandom;
      tick();
      bus.start = 1'b0;
      repeat (6) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {bus.A_cipher, bus.B_cipher}, 64'h0);
      chk("abort_flags", {61'h0, bus.done, bus.busy, 1'b0}, 64'h0);
      chk("abort_addr", 64'(bus.S_address), 64'h0);
      seen = 1'b0;
      repeat (3) begin
         tick();
         seen |= bus.done | bus.busy;
      end
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         seen |= bus.done | bus.busy;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      run($urandom, $urandom, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 500; k++) begin
         foreach (s_tab[m]) s_tab[m] = $urandom;
         a1 = $urandom;
         b1 = $urandom;
         run(a1, b1, 1'b0, 32'h0, 32'h0);
         chk("decipher", dec(bus.A_cipher, bus.B_cipher), {a1, b1});
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
